// File: rtl/io_request_arbiter_if.sv
// Shared types for the I/O request arbiter and the peripheral bus interface it masters.
package io_arb_pkg;
    typedef logic [3:0] core_id_t;
    typedef logic [3:0] thread_idx_t;

    typedef struct packed {
        logic        store;
        thread_idx_t thread_idx;
        logic [31:0] address;
        logic [31:0] value;
    } ioreq_packet_t;

    typedef struct packed {
        core_id_t    core;
        thread_idx_t thread_idx;
        logic [31:0] read_value;
    } iorsp_packet_t;
endpackage

interface io_bus_interface;
    logic        write_en;
    logic        read_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master(output write_en, read_en, address, write_data, input read_data);
    modport slave(input write_en, read_en, address, write_data, output read_data);
endinterface

// File: rtl/io_request_arbiter.sv
// Buffers I/O requests from several cores in per-core FIFOs and runs them one at a time,
// round-robin, on the shared peripheral bus, returning a tagged response to the requester.
module io_request_arbiter
    import io_arb_pkg::*;
#(
    parameter int NUM_REQUESTERS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] ior_request_valid,
    input  ioreq_packet_t             ior_request [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] ior_request_ready,
    output logic                      ia_response_valid,
    output iorsp_packet_t             ia_response,
    io_bus_interface.master           io_bus
);
    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    ioreq_packet_t             fifo_mem [NUM_REQUESTERS][FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr   [NUM_REQUESTERS];
    logic [PTR_W-1:0]          rd_ptr   [NUM_REQUESTERS];
    logic [CNT_W-1:0]          count    [NUM_REQUESTERS];
    logic [NUM_REQUESTERS-1:0] nonempty;
    logic [NUM_REQUESTERS-1:0] push;
    logic [NUM_REQUESTERS-1:0] pop;

    logic [1:0]       state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic [IDX_W-1:0] req_core;
    ioreq_packet_t    req_reg;
    logic [31:0]      resp_value;

    // Ready depends only on the registered count, so a pop frees a slot from the next cycle.
    always_comb begin
        nonempty          = '0;
        ior_request_ready = '0;
        push              = '0;
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            nonempty[i]          = (count[i] != '0);
            ior_request_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
            push[i]              = ior_request_valid[i] && ior_request_ready[i];
        end
    end

    always_comb begin
        int unsigned cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
            cand = (32'(last_grant) + k) % NUM_REQUESTERS;
            if (!grant_valid && nonempty[IDX_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (state == S_IDLE && grant_valid) pop[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
            if (push[i]) fifo_mem[i][wr_ptr[i]] <= ior_request[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
                else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= IDX_W'(NUM_REQUESTERS - 1);
            req_core   <= '0;
            req_reg    <= '0;
            resp_value <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        req_reg    <= fifo_mem[grant_idx][rd_ptr[grant_idx]];
                        req_core   <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    resp_value <= req_reg.store ? '0 : io_bus.read_data;
                    state      <= S_RESPOND;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.write_en   = (state == S_ISSUE) && req_reg.store;
    assign io_bus.read_en    = (state == S_ISSUE) && !req_reg.store;
    assign io_bus.address    = req_reg.address;
    assign io_bus.write_data = req_reg.value;

    assign ia_response_valid = (state == S_RESPOND);

    always_comb begin
        ia_response            = '0;
        ia_response.core       = core_id_t'(req_core);
        ia_response.thread_idx = req_reg.thread_idx;
        ia_response.read_value = resp_value;
    end
endmodule

// File: tb/tb_io_request_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts bus operations and responses.
module tb_io_request_arbiter;
    import io_arb_pkg::*;

    localparam int N = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]  valid;
    logic [N-1:0]  ready;
    ioreq_packet_t req [N];
    logic          rsp_valid;
    iorsp_packet_t rsp;

    io_bus_interface bus();

    io_request_arbiter #(.NUM_REQUESTERS(N), .FIFO_DEPTH(D)) dut (
        .clk               (clk),
        .reset             (rst),
        .ior_request_valid (valid),
        .ior_request       (req),
        .ior_request_ready (ready),
        .ia_response_valid (rsp_valid),
        .ia_response       (rsp),
        .io_bus            (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] slave_data(logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    // Slave returns data one cycle after read_en; otherwise noise.
    always @(posedge clk) bus.read_data <= bus.read_en ? slave_data(bus.address) : $urandom;

    typedef struct { int unsigned cyc; iorsp_packet_t r; } exp_rsp_t;
    typedef struct { int unsigned cyc; logic store; logic [31:0] addr; logic [31:0] data; } exp_bus_t;

    ioreq_packet_t mq [N][$];
    exp_rsp_t      exp_rsp[$];
    exp_bus_t      exp_bus[$];
    int unsigned   mlast = N - 1;
    int unsigned   mphase = 0;
    int unsigned   cyc = 0;
    logic [N-1:0]  macc = '0;

    always @(posedge clk or posedge rst) begin
        logic [N-1:0]  rdy;
        ioreq_packet_t pk;
        int unsigned   w;
        bit            found;
        if (rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            exp_rsp.delete();
            exp_bus.delete();
            mlast  = N - 1;
            mphase = 0;
            macc   = '0;
        end else begin
            cyc++;
            macc = '0;
            for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
            if (mphase == 0) begin
                found = 0;
                w = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && mq[(mlast + k) % N].size() > 0) begin
                        found = 1;
                        w = (mlast + k) % N;
                    end
                end
                if (found) begin
                    pk = mq[w].pop_front();
                    mlast = w;
                    exp_bus.push_back('{cyc, pk.store, pk.address, pk.value});
                    exp_rsp.push_back('{cyc + 2, '{core_id_t'(w), pk.thread_idx,
                                                   pk.store ? 32'h0 : slave_data(pk.address)}});
                    mphase = 1;
                end
            end else begin
                mphase = (mphase + 1) % 4;
            end
            for (int i = 0; i < N; i++) begin
                if (valid[i] && rdy[i]) begin
                    mq[i].push_back(req[i]);
                    macc[i] = 1'b1;
                end
            end
        end
    end

    task automatic fail(string name, logic [63:0] act, logic [63:0] expv);
        failures++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    int unsigned   re_cnt = 0, we_cnt = 0, ready1_low = 0;
    logic [31:0]   last_wdata = '0;
    iorsp_packet_t last_rsp;
    int unsigned   last_rsp_cyc = 0;
    int unsigned   rsp_core_log[$];
    int unsigned   rsp_thr_log[$];
    int unsigned   rsp_cyc_log[$];

    always @(negedge clk) begin
        exp_bus_t eb;
        exp_rsp_t er;
        if (rst) begin
            checks++;
            if (ready !== '1 || rsp_valid !== 1'b0 || rsp !== '0)
                fail("reset_outputs", {ready, rsp_valid, rsp}, {4'hF, 1'b0, 40'h0});
            checks++;
            if (bus.read_en !== 1'b0 || bus.write_en !== 1'b0 || bus.address !== '0 || bus.write_data !== '0)
                fail("reset_bus", {bus.read_en, bus.write_en, bus.address}, 64'h0);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (ready[i] !== (mq[i].size() < D)) fail($sformatf("ready%0d", i), ready[i], mq[i].size() < D);
            end
            if (ready[1] === 1'b0) ready1_low++;
            checks++;
            if (bus.read_en === 1'b1 && bus.write_en === 1'b1) fail("both_enables", 2'b11, 2'b00);
            if (bus.read_en === 1'b1) re_cnt++;
            if (bus.write_en === 1'b1) begin
                we_cnt++;
                last_wdata = bus.write_data;
            end
            if (bus.read_en === 1'b1 || bus.write_en === 1'b1) begin
                checks++;
                if (exp_bus.size() == 0) fail("bus_unexpected", bus.address, 0);
                else begin
                    eb = exp_bus.pop_front();
                    if (eb.cyc != cyc || bus.write_en !== eb.store || bus.read_en !== !eb.store ||
                        bus.address !== eb.addr || (eb.store && bus.write_data !== eb.data))
                        fail("bus_op", {bus.write_en, bus.address, bus.write_data[30:0]},
                             {eb.store, eb.addr, eb.data[30:0]});
                end
            end else if (exp_bus.size() > 0 && exp_bus[0].cyc <= cyc) begin
                checks++;
                eb = exp_bus.pop_front();
                fail("bus_missing", 0, eb.addr);
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (exp_rsp.size() == 0) fail("rsp_unexpected", rsp, 0);
                else begin
                    er = exp_rsp.pop_front();
                    if (er.cyc != cyc || rsp !== er.r) fail("rsp", rsp, er.r);
                end
                last_rsp = rsp;
                last_rsp_cyc = cyc;
                rsp_core_log.push_back(rsp.core);
                rsp_thr_log.push_back(rsp.thread_idx);
                rsp_cyc_log.push_back(cyc);
            end else if (exp_rsp.size() > 0 && exp_rsp[0].cyc <= cyc) begin
                checks++;
                er = exp_rsp.pop_front();
                fail("rsp_missing", 0, er.r);
            end
        end
    end

    int unsigned last_push_cyc = 0;

    // Called #1 after a rising edge; holds valid until the model sees the push.
    task automatic push_one(int p, ioreq_packet_t pk);
        int unsigned t = 0;
        req[p] = pk;
        valid[p] = 1'b1;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!macc[p] && t < 50);
        valid[p] = 1'b0;
        if (!macc[p]) begin
            checks++;
            fail("push_timeout", p, 0);
        end
        last_push_cyc = cyc;
    endtask

    task automatic wait_idle(int unsigned budget);
        int unsigned t = 0;
        bit busy;
        do begin
            @(posedge clk);
            #1;
            t++;
            busy = (exp_rsp.size() > 0) || (mphase != 0);
            for (int i = 0; i < N; i++) if (mq[i].size() > 0) busy = 1;
        end while (busy && t < budget);
        if (busy) begin
            checks++;
            fail("drain_timeout", t, budget);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int unsigned t;
        int unsigned exp_order[8];
        valid = '0;
        for (int i = 0; i < N; i++) req[i] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single load on port 2
        re_cnt = 0; we_cnt = 0;
        rsp_core_log.delete();
        push_one(2, '{store: 1'b0, thread_idx: 4'd1, address: 32'h100, value: 32'h0});
        wait_idle(40);
        checks++;
        if (rsp_core_log.size() != 1 || last_rsp !== {4'd2, 4'd1, 32'hDEADBEEF})
            fail("single_load", last_rsp, {4'd2, 4'd1, 32'hDEADBEEF});
        checks++;
        if (last_rsp_cyc != last_push_cyc + 3) fail("load_latency", last_rsp_cyc - last_push_cyc, 3);
        checks++;
        if (re_cnt != 1 || we_cnt != 0) fail("load_enables", {re_cnt[7:0], we_cnt[7:0]}, 16'h0100);

        // Store on port 0
        re_cnt = 0; we_cnt = 0;
        push_one(0, '{store: 1'b1, thread_idx: 4'd3, address: 32'h44, value: 32'h1234});
        wait_idle(40);
        checks++;
        if (re_cnt != 0 || we_cnt != 1 || last_wdata !== 32'h1234)
            fail("store_bus", {re_cnt[7:0], we_cnt[7:0], last_wdata}, {16'h0001, 32'h1234});
        checks++;
        if (last_rsp !== {4'd0, 4'd3, 32'h0}) fail("store_rsp", last_rsp, {4'd0, 4'd3, 32'h0});

        // Round-robin: two requests on every port, pushed together right after reset
        do_reset();
        rsp_core_log.delete();
        rsp_cyc_log.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++)
                req[i] = '{store: 1'b0, thread_idx: 4'(r), address: 32'(16 * i + r), value: 32'h0};
            valid = '1;
            @(posedge clk);
            #1;
        end
        valid = '0;
        wait_idle(80);
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        checks++;
        if (rsp_core_log.size() != 8) fail("rr_count", rsp_core_log.size(), 8);
        else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (rsp_core_log[k] != exp_order[k]) fail($sformatf("rr_grant%0d", k), rsp_core_log[k], exp_order[k]);
            end
            for (int k = 1; k < 8; k++) begin
                checks++;
                if (rsp_cyc_log[k] - rsp_cyc_log[k-1] != 4) fail("rr_spacing", rsp_cyc_log[k] - rsp_cyc_log[k-1], 4);
            end
        end

        // Full FIFO: keep the bus busy with port 0, then overfill port 1
        ready1_low = 0;
        rsp_core_log.delete();
        rsp_thr_log.delete();
        push_one(0, '{store: 1'b1, thread_idx: 4'd9, address: 32'h8, value: 32'h77});
        for (int k = 0; k <= D; k++)
            push_one(1, '{store: 1'b0, thread_idx: 4'(k), address: 32'(32'h200 + k), value: 32'h0});
        wait_idle(80);
        checks++;
        if (ready1_low == 0) fail("full_ready_low", ready1_low, 1);
        checks++;
        if (rsp_thr_log.size() != D + 2) fail("full_count", rsp_thr_log.size(), D + 2);
        else begin
            for (int k = 0; k <= D; k++) begin
                checks++;
                if (rsp_core_log[k+1] != 1 || rsp_thr_log[k+1] != k)
                    fail("full_order", {rsp_core_log[k+1][3:0], rsp_thr_log[k+1][3:0]}, {4'd1, 4'(k)});
            end
        end

        // Reset during WAIT with two entries queued on port 3
        push_one(3, '{store: 1'b0, thread_idx: 4'd5, address: 32'h300, value: 32'h0});
        push_one(3, '{store: 1'b0, thread_idx: 4'd6, address: 32'h304, value: 32'h0});
        push_one(3, '{store: 1'b1, thread_idx: 4'd7, address: 32'h308, value: 32'h5});
        t = 0;
        while (mphase != 2 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (mphase != 2) fail("reach_wait", mphase, 2);
        rsp_core_log.delete();
        do_reset();
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (rsp_core_log.size() != 0) fail("reset_no_rsp", rsp_core_log.size(), 0);
        req[0] = '{store: 1'b0, thread_idx: 4'd2, address: 32'h10, value: 32'h0};
        req[2] = '{store: 1'b0, thread_idx: 4'd4, address: 32'h20, value: 32'h0};
        valid = 4'b0101;
        @(posedge clk);
        #1 valid = '0;
        wait_idle(40);
        checks++;
        if (rsp_core_log.size() != 2 || rsp_core_log[0] != 0 || rsp_core_log[1] != 2)
            fail("post_reset_order", rsp_core_log.size() > 0 ? rsp_core_log[0] : 99, 0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                req[i] = '{store: 1'($urandom), thread_idx: 4'($urandom), address: $urandom, value: $urandom};
                valid[i] = ($urandom_range(0, 3) == 0);
            end
            @(posedge clk);
            #1;
        end
        valid = '0;
        wait_idle(200);
        checks++;
        if (exp_bus.size() != 0) fail("bus_leftover", exp_bus.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
